// File: rtl/seq_word_adder.sv
// seq_word_adder: multi-cycle 12-bit adder built around an external 3-bit ripple slice
module seq_word_adder #(
    parameter int DIGIT_W = 3,
    parameter int DIGITS  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [DIGIT_W*DIGITS-1:0]  i_op_a,
    input  logic [DIGIT_W*DIGITS-1:0]  i_op_b,
    input  logic                       i_op_cin,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DIGIT_W*DIGITS-1:0]  o_result,
    output logic                       o_result_cout,
    output logic [DIGIT_W-1:0]         o_add_a,
    output logic [DIGIT_W-1:0]         o_add_b,
    output logic                       o_add_cin,
    input  logic [DIGIT_W-1:0]         i_add_sum,
    input  logic                       i_add_cout
);
    localparam int W     = DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept;
    logic               w_run;
    logic               w_last;

    assign w_accept      = (r_state == IDLE) && i_in_valid;
    assign w_run         = (r_state == RUN);
    assign w_last        = (r_cnt == CNT_W'(DIGITS - 1));
    assign o_result      = r_res;
    assign o_result_cout = r_carry;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake/slice outputs; the slice sees zeros outside RUN
    always_comb begin
        w_next      = r_state;
        o_in_ready  = (r_state == IDLE);
        o_out_valid = (r_state == DONE);
        o_add_a     = w_run ? r_a[DIGIT_W-1:0] : '0;
        o_add_b     = w_run ? r_b[DIGIT_W-1:0] : '0;
        o_add_cin   = w_run ? r_carry : 1'b0;
        if (w_accept)                          w_next = RUN;
        else if (w_run && w_last)              w_next = DONE;
        else if (o_out_valid && i_out_ready)   w_next = IDLE;
    end

    // Datapath: latch operands on accept, then consume one digit per RUN cycle,
    // inserting each slice sum at the top so digit 0 lands in the low bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_res   <= '0;
            r_carry <= i_op_cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> DIGIT_W;
            r_b     <= r_b >> DIGIT_W;
            r_res   <= {i_add_sum, r_res[W-1:DIGIT_W]};
            r_carry <= i_add_cout;
            r_cnt   <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_word_adder.sv
// tb_seq_word_adder: directed self-checking bench with a behavioural 3-bit slice
module tb_seq_word_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        op_cin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] result;
    logic        result_cout;
    logic [2:0]  add_a;
    logic [2:0]  add_b;
    logic        add_cin;
    logic [2:0]  add_sum;
    logic        add_cout;
    logic [3:0]  slice;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;
    logic [2:0] da [4];
    logic [2:0] db [4];
    logic       dc [4];

    always #5 clk = ~clk;

    assign slice    = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};
    assign add_sum  = slice[2:0];
    assign add_cout = slice[3];

    seq_word_adder dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op_a(op_a), .i_op_b(op_b), .i_op_cin(op_cin),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_result(result), .o_result_cout(result_cout),
        .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
        .i_add_sum(add_sum), .i_add_cout(add_cout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set, record slice drives for cycles T..T+3, stop in DONE
    task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic cin);
        in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin;
        step();
        in_valid = 1'b0; op_a = ~a; op_b = ~b; op_cin = ~cin;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) begin
                da[lat] = add_a; db[lat] = add_b; dc[lat] = add_cin;
            end
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_chk++; if (result !== 12'h000 || result_cout !== 1'b0) $display("FAIL reset_result got %h/%b want 000/0", result, result_cout); else n_pass++;
        n_chk++; if ({add_a, add_b, add_cin} !== 7'd0) $display("FAIL reset_slice got %b%b%b want 0", add_a, add_b, add_cin); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero();
        run_op(12'h000, 12'h000, 1'b0);
        n_chk++; if (lat !== 4) $display("FAIL zero_latency got %0d want 4", lat); else n_pass++;
        n_chk++; if (result !== 12'h000 || result_cout !== 1'b0) $display("FAIL zero_result got %h/%b want 000/0", result, result_cout); else n_pass++;
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL zero_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_full_wrap();
        run_op(12'hFFF, 12'h001, 1'b0);
        n_chk++; if (lat !== 4) $display("FAIL wrap_latency got %0d want 4", lat); else n_pass++;
        n_chk++; if (result !== 12'h000 || result_cout !== 1'b1) $display("FAIL wrap_result got %h/%b want 000/1", result, result_cout); else n_pass++;
        n_chk++; if ({dc[0], dc[1], dc[2], dc[3]} !== 4'b0111) $display("FAIL wrap_digit_carries got %b%b%b%b want 0111", dc[0], dc[1], dc[2], dc[3]); else n_pass++;
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_carry_ripple();
        logic [12:0] e;
        run_op(12'hABC, 12'h123, 1'b1);
        n_chk++; if (result !== 12'hBE0 || result_cout !== 1'b0) $display("FAIL ripple_result got %h/%b want be0/0", result, result_cout); else n_pass++;
        n_chk++; if (da[0] !== 3'b100 || db[0] !== 3'b011 || dc[0] !== 1'b1) $display("FAIL ripple_digit0 got %b/%b/%b want 100/011/1", da[0], db[0], dc[0]); else n_pass++;
        n_chk++; if ({da[3], da[2], da[1], da[0]} !== 12'hABC || {db[3], db[2], db[1], db[0]} !== 12'h123) $display("FAIL ripple_digits got %h%h%h%h want abc", da[3], da[2], da[1], da[0]); else n_pass++;
        out_ready = 1'b1; step(); out_ready = 1'b0;
        e = 13'h0555 + 13'h0AAA + 13'd1;
        run_op(12'h555, 12'hAAA, 1'b1);
        n_chk++; if ({result_cout, result} !== e) $display("FAIL ripple_alt got %b/%h want %b/%h", result_cout, result, e[12], e[11:0]); else n_pass++;
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        run_op(12'h3C5, 12'h2A7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1; op_a = 12'h111; op_b = 12'h222;
            step();
            n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL bp_hold%0d got vld=%b rdy=%b want 1/0", i, out_valid, in_ready); else n_pass++;
            n_chk++; if (result !== 12'h66C || result_cout !== 1'b0) $display("FAIL bp_result%0d got %h/%b want 66c/0", i, result, result_cout); else n_pass++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); else n_pass++;
        step();
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_no_accept got rdy=%b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1; op_a = 12'h7FF; op_b = 12'h7FF; op_cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_flags got rdy=%b vld=%b want 1/0", in_ready, out_valid); else n_pass++;
        n_chk++; if (result !== 12'h000 || result_cout !== 1'b0 || {add_a, add_b, add_cin} !== 7'd0) $display("FAIL midrst_clear got %h/%b slice=%b%b%b want 0", result, result_cout, add_a, add_b, add_cin); else n_pass++;
        run_op(12'h005, 12'h003, 1'b0);
        n_chk++; if (lat !== 4 || result !== 12'h008 || result_cout !== 1'b0) $display("FAIL midrst_next got lat=%0d %h/%b want 4 008/0", lat, result, result_cout); else n_pass++;
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] ta [3] = '{12'h123, 12'hFFE, 12'h800};
        logic [11:0] tb [3] = '{12'h456, 12'h001, 12'h800};
        logic        tc [3] = '{1'b0, 1'b1, 1'b1};
        int acc_cyc [3];
        int ni = 0, no = 0, cyc = 0;
        logic acc;
        logic [12:0] e;
        in_valid = 1'b1; op_a = ta[0]; op_b = tb[0]; op_cin = tc[0]; out_ready = 1'b1;
        while (no < 3 && cyc < 80) begin
            acc = in_ready && in_valid;
            if (out_valid) begin
                e = {1'b0, ta[no]} + {1'b0, tb[no]} + {12'd0, tc[no]};
                n_chk++; if ({result_cout, result} !== e) $display("FAIL b2b_result%0d got %b/%h want %b/%h", no, result_cout, result, e[12], e[11:0]); else n_pass++;
                no++;
            end
            if (acc) begin
                acc_cyc[ni] = cyc;
                ni++;
            end
            step();
            cyc++;
            if (acc) begin
                if (ni < 3) begin
                    op_a = ta[ni]; op_b = tb[ni]; op_cin = tc[ni];
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_chk++; if (no !== 3 || ni !== 3) $display("FAIL b2b_timeout got %0d results %0d accepts want 3/3", no, ni); else n_pass++;
        n_chk++; if (ni == 3 && (acc_cyc[1] - acc_cyc[0] !== 6 || acc_cyc[2] - acc_cyc[1] !== 6)) $display("FAIL b2b_spacing got %0d,%0d want 6,6", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;
        test_reset();
        test_zero();
        test_full_wrap();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_word_adder.md
# seq_word_adder

Multi-cycle 12-bit adder controller that sits directly around the 3-bit ripple adder slice. It accepts a pair of 12-bit operands plus carry-in via a valid/ready handshake. It feeds the slice one 3-bit digit per cycle, least-significant digit first, and registers the slice's sum and carry-out. It returns the assembled 12-bit result and final carry through a second valid/ready handshake.

## Interface

Parameters:
- DIGIT_W, 3, width of one digit; fixed to the adder slice width, not overridable in practice.
- DIGITS, 4, digits per operand; operand width = DIGIT_W*DIGITS = 12.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand set available.
- in_ready  out  1  block can accept operands.
- op_a  in  12  operand A.
- op_b  in  12  operand B.
- op_cin  in  1  carry-in into digit 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  12  A+B+cin, modulo 2^12.
- result_cout  out  1  carry out of bit 11.
- add_a  out  3  digit of A driven to slice.
- add_b  out  3  digit of B driven to slice.
- add_cin  out  1  carry driven to slice.
- add_sum  in  3  slice sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  slice carry-out.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch op_a/op_b into shift registers, latch op_cin into carry register, clear digit counter to 0 and result register, go to RUN.
- RUN:
  - add_a/add_b = low 3 bits of the A/B shift registers.
  - add_cin = carry register.
  - Each cycle: shift add_sum into result from the top (result register shifts right by 3), load add_cout into carry register, shift A/B right by 3, increment counter.
  - After the cycle with counter==DIGITS-1, go to DONE.
- DONE:
  - out_valid=1.
  - result = assembled register; digit 0 ends in bits [2:0].
  - result_cout = carry register.
  - On out_ready, go to IDLE.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- Inputs are sampled only on the accepting edge. Changes to op_* afterwards have no effect.
- in_valid is ignored outside IDLE. No operand buffering.
- Arithmetic is unsigned, modulo 4096. Overflow is reported only through result_cout.
- The slice's combinational output is captured on the same edge it is presented. There is no pipeline inside the slice.

## Timing

- Reset values, applied at the first rising edge with rst_n=0:
  - state=IDLE, in_ready=1, out_valid=0, result=0, result_cout=0.
  - add_a=0, add_b=0, add_cin=0, counter=0.
- Latency:
  - Operands accepted at edge T.
  - RUN occupies cycles T..T+3; digit k is presented during cycle T+k.
  - out_valid rises after edge T+4 (4 cycles).
- out_valid and result hold stable while out_ready=0, indefinitely.
- Output handshake completes at the edge where out_valid&&out_ready. in_ready is 1 in the following cycle.
- Throughput: one operation per 6 cycles minimum (1 accept + 4 RUN + 1 DONE). No accept-during-DONE overlap.
- rst_n low in any state, including mid-RUN or DONE, aborts the operation. All outputs return to reset values at that edge, and the partial result is discarded.
- out_ready asserted while out_valid=0 is ignored.

## Test plan

- Zero: op_a=12'h000, op_b=12'h000, op_cin=0 → result=12'h000, result_cout=0, out_valid 4 cycles after accept.
- Full wrap: op_a=12'hFFF, op_b=12'h001, op_cin=0 → result=12'h000, result_cout=1. add_cin=1 observed on digits 1..3.
- Carry-in ripple: op_a=12'hABC, op_b=12'h123, op_cin=1 → result=12'hBE0, result_cout=0. Digit-0 drive is add_a=3'b100, add_b=3'b011, add_cin=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → result, result_cout and out_valid stable; in_ready=0; in_valid pulses are ignored. Release → in_ready=1 next cycle.
- Reset mid-RUN: accept 12'h7FF+12'h7FF, drop rst_n during the 2nd RUN cycle → next cycle in_ready=1, out_valid=0, result=0. A following 12'h005+12'h003 yields 12'h008.
- Back-to-back: in_valid held high with out_ready=1 for 3 operations → accepts spaced exactly 6 cycles apart, each result correct against a reference model.
